// File: rtl/eight_bit_unsigned_array_multiplier.sv
// 8x8 unsigned carry-save array multiplier with an 8-bit addend: mul = multiplicand*multiplier + c_in.
// Define PIPE_STAGE_EN to register the array after adder row 4 (latency 2 instead of 1).
module eight_bit_unsigned_array_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  multiplicand,
    input  logic [7:0]  multiplier,
    input  logic [7:0]  c_in,
    input  logic        in_valid,
    output logic [15:0] mul,
    output logic        out_valid
);

    // One carry-save row: folds partial-product row pp into the (sum, carry) vectors.
    // Column 0 sees no shifted partial product, so it degenerates to a half adder.
    // Returns {retired result bit, next sum vector, next carry vector}.
    function automatic logic [16:0] csa_row(input logic [7:0] s,
                                            input logic [7:0] c,
                                            input logic [7:0] pp);
        logic [7:0] x;
        logic [7:0] sum;
        logic [7:0] cy;
        x   = {pp[6:0], 1'b0};
        sum = s ^ c ^ x;
        cy  = (s & c) | (s & x) | (c & x);
        return {sum[0], pp[7], sum[7:1], cy};
    endfunction

    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [7:0] c_q;
    logic       v_q;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= in_valid;
            if (in_valid) begin
                a_q <= multiplicand;
                b_q <= multiplier;
                c_q <= c_in;
            end
        end
    end

    // Rows 1..4; c_in enters as the carry vector of the first row.
    logic [7:0] f_s;
    logic [7:0] f_c;
    logic [3:0] f_lo;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        f_s  = a_q & {8{b_q[0]}};
        f_c  = c_q;
        f_lo = '0;
        for (int i = 1; i <= 4; i++) begin
            {f_lo[i-1], f_s, f_c} = csa_row(f_s, f_c, a_q & {8{b_q[i]}});
        end
    end

    logic [7:0] m_s;
    logic [7:0] m_c;
    logic [7:0] m_a;
    logic [2:0] m_b;
    logic [3:0] m_lo;
    logic       m_v;

`ifdef PIPE_STAGE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_s  <= '0;
            m_c  <= '0;
            m_a  <= '0;
            m_b  <= '0;
            m_lo <= '0;
            m_v  <= 1'b0;
        end else begin
            m_s  <= f_s;
            m_c  <= f_c;
            m_a  <= a_q;
            m_b  <= b_q[7:5];
            m_lo <= f_lo;
            m_v  <= v_q;
        end
    end
`else
    always_comb begin
        m_s  = f_s;
        m_c  = f_c;
        m_a  = a_q;
        m_b  = b_q[7:5];
        m_lo = f_lo;
        m_v  = v_q;
    end
`endif

    // Rows 5..7, then a ripple-carry row resolves the remaining sum/carry vectors into bits 15:7.
    logic [7:0]  b_s;
    logic [7:0]  b_c;
    logic [2:0]  b_lo;
    logic [8:0]  hi;
    logic        rc;
    logic [15:0] product;

    always_comb begin
        b_s  = m_s;
        b_c  = m_c;
        b_lo = '0;
        for (int i = 0; i < 3; i++) begin
            {b_lo[i], b_s, b_c} = csa_row(b_s, b_c, m_a & {8{m_b[i]}});
        end
        rc = 1'b0;
        hi = '0;
        for (int k = 0; k < 8; k++) begin
            hi[k] = b_s[k] ^ b_c[k] ^ rc;
            rc    = (b_s[k] & b_c[k]) | (rc & (b_s[k] ^ b_c[k]));
        end
        hi[8] = rc;
    end

    assign product = {hi, b_lo, m_lo};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= m_v;
            if (m_v) begin
                mul <= product;
            end
        end
    end

endmodule

// File: tb/tb_eight_bit_unsigned_array_multiplier.sv
// Self-checking bench for eight_bit_unsigned_array_multiplier: directed cases plus random streaming
// against an arithmetic delay-line model. Define PIPE_STAGE_EN to check the 2-cycle build.
module tb_eight_bit_unsigned_array_multiplier;

`ifdef PIPE_STAGE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [7:0]  c_in;
    logic        in_valid;
    logic [15:0] mul;
    logic        out_valid;

    eight_bit_unsigned_array_multiplier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .c_in         (c_in),
        .in_valid     (in_valid),
        .mul          (mul),
        .out_valid    (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_passed = 0;

    // Reference: exact arithmetic pushed through an L-deep delay line, output holds when not valid.
    bit pipe_v [L];
    int pipe_d [L];
    bit m_valid = 1'b0;
    int m_mul   = 0;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) n_passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    // Advance one clock edge, update the model with the sampled inputs, then compare just after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < L; i++) begin
                pipe_v[i] = 1'b0;
                pipe_d[i] = 0;
            end
            m_valid = 1'b0;
            m_mul   = 0;
        end else begin
            m_valid = pipe_v[L-1];
            if (pipe_v[L-1]) m_mul = pipe_d[L-1];
            for (int i = L - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = in_valid;
            pipe_d[0] = int'(multiplicand) * int'(multiplier) + int'(c_in);
        end
        #1;
        check("model_mul", int'(mul), m_mul);
        check("model_valid", int'(out_valid), int'(m_valid));
    endtask

    task automatic drive(input int a, input int b, input int c, input bit v);
        multiplicand = 8'(a);
        multiplier   = 8'(b);
        c_in         = 8'(c);
        in_valid     = v;
    endtask

    // Present one operand set for one cycle, then wait L cycles and check the result directly.
    task automatic one_shot(input string tag, input int a, input int b, input int c, input int expected);
        drive(a, b, c, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0);
        for (int i = 0; i < L; i++) tick();
        check({tag, "_mul"}, int'(mul), expected);
        check({tag, "_valid"}, int'(out_valid), 1);
    endtask

    int exp_q[$];
    int exp_v;
    int pulses;
    int ra;
    int rb;

    initial begin
        for (int i = 0; i < L; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = 0;
        end

        // Reset held for two edges with valid operands present.
        rst_n = 1'b0;
        drive(200, 100, 0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_mul", int'(mul), 0);
            check("rst_valid", int'(out_valid), 0);
        end

        // First edge with rst_n=1 accepts operands.
        rst_n = 1'b1;
        one_shot("first", 7, 9, 3, 66);

        one_shot("max_prod", 255, 255, 0, 65025);
        one_shot("zero_a", 0, 255, 0, 0);
        one_shot("max_cin", 255, 255, 255, 65280);
        one_shot("cin_only", 0, 0, 77, 77);
        one_shot("one_a", 1, 173, 20, 193);
        one_shot("one_b", 91, 1, 0, 91);

        // Streaming: one new operand pair every cycle.
        for (int i = 0; i < 100 + L; i++) begin
            if (i < 100) begin
                ra = int'($urandom_range(254, 0));
                rb = int'($urandom_range(254, 0));
                drive(ra, rb, 0, 1'b1);
                exp_q.push_back(ra * rb);
            end else begin
                drive(0, 0, 0, 1'b0);
            end
            tick();
            if (i >= L) begin
                exp_v = exp_q.pop_front();
                check("stream_mul", int'(mul), exp_v);
                check("stream_valid", int'(out_valid), 1);
            end
        end

        // Hold: a single result must persist while no new operands arrive.
        drive(12, 13, 0, 1'b1);
        tick();
        drive(0, 0, 0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) pulses++;
            if (i >= L - 1) check("hold_mul", int'(mul), 156);
        end
        check("hold_pulses", pulses, 1);

        // Mid-operation reset discards the in-flight result.
        drive(3, 5, 0, 1'b1);
        tick();
        rst_n = 1'b0;
        drive(0, 0, 0, 1'b0);
        tick();
        check("midrst_mul", int'(mul), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_valid", int'(out_valid), 0);
            check("midrst_hold", int'(mul), 0);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/eight_bit_unsigned_array_multiplier.md
EIGHT_BIT_UNSIGNED_ARRAY_MULTIPLIER -- requirements
Module: eight_bit_unsigned_array_multiplier

Interface
REQ-001 The block SHALL have no parameters; all operand widths are fixed at 8 bits and the product width at 16 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 multiplicand  input  8  unsigned operand A.
REQ-006 multiplier  input  8  unsigned operand B.
REQ-007 c_in  input  8  unsigned addend, injected as the carry-in vector of the first adder row.
REQ-008 in_valid  input  1  operands valid this cycle.
REQ-009 mul  output  16  unsigned result, registered.
REQ-010 out_valid  output  1  mul holds a new result this cycle.

Function
REQ-011 The datapath SHALL be a carry-save array multiplier:
- 64 AND partial-product bits;
- 7 rows of full/half adders;
- ripple-carry final row.
No behavioural "*" operator is allowed.
REQ-012 Result SHALL be mul = multiplicand*multiplier + c_in, computed exactly in 16 bits.
REQ-013 The maximum result is 255*255+255 = 65280, so the result SHALL never overflow 16 bits and no truncation SHALL occur.
REQ-014 With c_in = 0, mul SHALL equal the plain unsigned product.
REQ-015 Operands SHALL be sampled on the rising clk edge when in_valid=1.
REQ-016 Latency: mul/out_valid SHALL update on the edge after sampling (1 cycle) in the default build.
REQ-017 out_valid SHALL be in_valid delayed by the pipeline latency.
REQ-018 mul SHALL hold its last value while out_valid=0.
REQ-019 Back-to-back in_valid every cycle SHALL be accepted: throughput is one result per cycle, with no stall and no backpressure.
REQ-020 Boundary cases SHALL produce exact results:
- operand 0 gives mul=c_in;
- operand 1 gives mul=other operand+c_in;
- 255*255 gives 65025.

Reset
REQ-021 While rst_n=0 at a rising clk edge, mul SHALL become 16'h0000, out_valid 0, and all pipeline registers 0.
REQ-022 Reset SHALL take priority over in_valid.
REQ-023 A reset asserted mid-operation SHALL discard every in-flight result; no out_valid SHALL be produced for operands sampled before reset.
REQ-024 The first operand set SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-025 Macro PIPE_STAGE_EN:
- when defined, a register stage SHALL be inserted after adder row 4, latency 2 cycles, covered by reset, out_valid delayed accordingly;
- when undefined, the array is combinational between the input and output registers, latency 1 cycle.
REQ-026 The arithmetic result SHALL be identical in both builds.

Verification
REQ-027 A bench SHALL check the following after reset (latency L = 1, or 2 with PIPE_STAGE_EN):
- Reset: rst_n=0 for 2 cycles with in_valid=1, A=200, B=100 -> mul=0 and out_valid=0 throughout.
- Extremes: A=255, B=255, c_in=0 -> mul=65025 after L; A=0, B=255, c_in=0 -> mul=0.
- Carry-in: A=255, B=255, c_in=255 -> mul=65280; A=0, B=0, c_in=77 -> mul=77.
- Streaming: 100 consecutive random A, B in 0..254 with c_in=0, in_valid=1 every cycle -> each mul equals A*B exactly L cycles later, out_valid continuously 1.
- Hold: one valid A=12, B=13, then in_valid=0 for 5 cycles -> mul stays 156, out_valid pulses once.
- Mid-operation reset: in_valid=1 with A=3, B=5, rst_n=0 on the next edge -> no out_valid and mul=0 afterwards.
